// File: rtl/regfile_wb.sv
// Architectural register file fed by the writeback stage: two combinational
// read ports, r0 hardwired to zero, optional same-cycle write-to-read bypass.
module regfile_wb #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_writeEnable,
  input  logic [4:0]       ctrl_writeReg,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic [4:0]       ctrl_readRegA,
  input  logic [4:0]       ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB
);

  localparam int unsigned IDX_W = 5;

  // r0 has no storage; indices 1..NREGS-1 are real registers
  logic [WIDTH-1:0] regs [1:NREGS-1];
  logic [NREGS-1:0] wr_sel;
  logic             wr_live;
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;
  logic             byp_a;
  logic             byp_b;

  // One-hot write decode qualified by the write strobe
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      wr_sel[i] = ctrl_writeEnable && (ctrl_writeReg == IDX_W'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < int'(NREGS); i++) begin
        if (wr_sel[i]) regs[i] <= data_writeReg;
      end
    end
  end

  // Read muxes; index 0 and out-of-range indices return zero
  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      if (ctrl_readRegA == IDX_W'(i)) stored_a = regs[i];
      if (ctrl_readRegB == IDX_W'(i)) stored_b = regs[i];
    end
  end

  // Bypass is suppressed under reset so the reset cycle reads zero
  assign wr_live = (BYPASS != 0) && ctrl_writeEnable && !reset && (ctrl_writeReg != '0);
  assign byp_a   = wr_live && (ctrl_writeReg == ctrl_readRegA);
  assign byp_b   = wr_live && (ctrl_writeReg == ctrl_readRegB);

  assign data_readRegA = byp_a ? data_writeReg : stored_a;
  assign data_readRegB = byp_b ? data_writeReg : stored_b;

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Architectural register file that consumes the writeback stage's outputs: write data, write register index and write enable from the MEM/WB decoder.
- Provides two combinational read ports to the decode stage.
- 32 registers × 32 bits; r0 hardwired to zero.
- Optional internal write-to-read bypass, so a writeback and a decode-stage read of the same register in the same cycle return the new value without a pipeline stall.

Parameters:
- WIDTH, 32, register data width in bits
- NREGS, 32, number of architectural registers (index width fixed at 5)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return the stored value only

Ports:
- clock  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high; clears every register
- ctrl_writeEnable  input  1  write strobe from the writeback decoder
- ctrl_writeReg  input  5  destination register index
- data_writeReg  input  WIDTH  write data (ALU result, load data, setx immediate, or exception code)
- ctrl_readRegA  input  5  read port A index
- ctrl_readRegB  input  5  read port B index
- data_readRegA  output  WIDTH  read port A data
- data_readRegB  output  WIDTH  read port B data

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high. While reset=1 at a rising edge, all NREGS registers become 0 and any write that cycle is discarded.
- Reset values of outputs: read outputs are combinational. After reset they read 0 for every index, including during the reset cycle with BYPASS=1, because the bypass is gated by ~reset.
- Write: at a rising edge with reset=0, ctrl_writeEnable=1 and ctrl_writeReg!=0, reg[ctrl_writeReg] <= data_writeReg. Write latency is 1 cycle; the value is visible from storage from the next cycle on.
- r0: writes with ctrl_writeReg=0 are ignored. Reads of index 0 always return 0, with no bypass for index 0.
- r30 (exception/status) and r31 (link) are ordinary storage here. Their special meaning is produced upstream, so no special casing.
- Read: purely combinational from the indices, with zero cycles of latency.
- Bypass (BYPASS=1): data_readRegX = data_writeReg whenever all of the following hold; otherwise data_readRegX = stored reg[ctrl_readRegX].
  - ctrl_writeEnable=1
  - reset=0
  - ctrl_writeReg!=0
  - ctrl_writeReg==ctrl_readRegX
- Bypass ports: ports A and B are bypassed independently; both may bypass in the same cycle.
- BYPASS=0: reads always return stored contents. The same-cycle writer's value appears on the next cycle.
- Simultaneous events:
  - Reset has priority over write.
  - Read and write to the same index in one cycle follows the bypass rule above.
  - A and B reading the same index return identical data.
- Unknown/undriven write inputs while ctrl_writeEnable=0 must not corrupt storage.
- Storage implementation:
  - Per-register enable comes from a 5-to-32 one-hot decoder ANDed with ctrl_writeEnable.
  - Read ports are 32:1 muxes, structural or behavioural.
  - No latches; all storage is edge-triggered.
- Reset mid-operation: a write pending in the same edge as reset is lost. The register reads 0 on the following cycle.

Test Plan:
- Reset, then read all indices 0..31 on both ports -> every read returns 32'h0.
- Write r5=32'hDEADBEEF, next cycle read A=5, B=5 -> both ports return 32'hDEADBEEF; other registers still 0.
- Write r0=32'hFFFFFFFF with we=1, next cycle read A=0 -> 32'h0. In the same cycle as a write to r0, read A=0 -> 32'h0 (no bypass).
- BYPASS=1: r7 holds 32'h1; in one cycle write r7=32'h2 while reading A=7, B=7 -> both show 32'h2 that cycle. Repeat with BYPASS=0 -> 32'h1 that cycle, 32'h2 next cycle.
- Writeback-style sequence:
  - Write r30=32'h3 (overflow code) and r31=32'h40 (jal link) on consecutive cycles, then read A=30, B=31 -> 32'h3, 32'h40.
  - we=0 with ctrl_writeReg=30 and data=32'hAAAA -> r30 unchanged.
- Write r12=32'h1234 asserted in the same cycle as reset=1, then read A=12 the next cycle -> 32'h0. A subsequent write with reset=0 -> 32'h1234.
